ld_rs: RTL
==========

# ld_rs

Load reservation station feeding the LD unit. It holds up to four LD/LDR instructions from dispatch and captures missing operands by snooping the common data bus (CDB). It issues one operand-complete load at a time to the LD unit as a single-cycle valid pulse, gated by the LD unit's busy flag. Each entry's tag doubles as the `rs_num` that the LD unit returns with its result.

## Interface
Parameters:
- `BASE_ID`, default 6'd16: tag of entry 0; entry i has tag `BASE_ID + i`.
- `N`, default 4: number of entries. Fixed at 4 in this revision.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `d_valid` in 1: dispatch request; ignored while `full`.
- `d_op` in 4: opcode, `LD`=4 or `LDR`=5.
- `d_pc` in 16: instruction PC, forwarded for prefetcher training.
- `d_r0`, `d_r1` in 1: operand 0/1 ready.
- `d_v0`, `d_v1` in 16: operand value if ready, otherwise producer tag in [5:0].
- `free_id` out 6: tag that the next accepted dispatch receives (combinational).
- `full` out 1: no free entry (combinational).
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_rs_num` in 6: CDB producer tag.
- `cdb_data` in 16: CDB value.
- `ld_busy` in 1: LD unit `busy`.
- `valid` out 1; `rs_num` out 6; `op` out 4; `pc` out 16; `val0`, `val1` out 16: issue bus to the LD unit, registered.

## Operation
- Entry state: valid, op, pc, r0, v0, r1, v1.
- `LD` ignores operand 1: r1 is forced to 1 at dispatch.
- Allocation:
  - The lowest-index free entry receives the dispatch.
  - `free_id` = `BASE_ID` + that index.
  - `full` = all four entries valid.
- CDB capture: on `cdb_valid`, every valid entry with rX==0 and v0[5:0] (or v1[5:0]) == `cdb_rs_num` latches `cdb_data` and sets rX=1.
- Dispatch bypass: if a dispatched operand is not ready and its tag matches a CDB broadcast in the same cycle, the entry is written already ready with `cdb_data`.
- Ready: an entry is ready when it is valid, r0=1 and r1=1, all evaluated on registered state at the start of the cycle.
- Issue:
  - Condition: `ld_busy`==0, `valid` currently 0, and at least one entry ready.
  - Selection: lowest-index ready entry (see Configuration).
  - Effect: at the edge, the issue bus is loaded, `valid` is set to 1, and the entry is freed.
- Pulse rule: `valid` is deasserted on the following edge unconditionally, so it is never high two cycles in a row.
- Issue and dispatch in the same cycle:
  - Allowed.
  - The freed entry is not reusable until the next cycle, because `free_id`/`full` are based on pre-edge state.
- Unused bus values: when `valid`=0, `rs_num`/`op`/`pc`/`val0`/`val1` hold their last values. `val1` is a don't-care for `LD`.

## Timing
- Reset values: all entries invalid; `valid`=0; `rs_num`=0; `op`=0; `pc`=0; `val0`=`val1`=0; `full`=0; `free_id`=`BASE_ID`.
- Reset asserted mid-operation flushes every entry immediately. An in-flight `valid` pulse is cleared asynchronously.
- Minimum latency, operand-complete dispatch: dispatched at edge k, `valid` high after edge k+1, if `ld_busy` was low in cycle k+1.
- Minimum latency, CDB-woken entry: broadcast at edge k, issue after edge k+1.
- Back-to-back issues are at least two cycles apart. The actual gap is set by `ld_busy`, which rises combinationally with `valid`.

## Configuration
- `LD_RS_OLDEST_FIRST_EN` defined:
  - Each entry keeps a 2-bit age, set to 0 on dispatch and incremented on each dispatch to another entry.
  - Issue selects the ready entry with the highest age; ties go to the lowest index.
- `LD_RS_OLDEST_FIRST_EN` undefined: lowest-index-ready selection, and no age storage is built.

## Structure
- Shared package `ld_pkg`:
  - opcode constants `OP_LD`=4 and `OP_LDR`=5;
  - the entry struct typedef;
  - `TAG_W`=6.
- Sub-module `ld_rs_pick`: combinational N-way ready/age priority selector returning index and hit. This is the natural sub-module.

## Test plan
- Dispatch LD, r0=1, v0=16'h0040, `ld_busy`=0 -> after two edges `valid`=1, `rs_num`=16, `val0`=16'h0040 for exactly one cycle; `full`=0.
- Dispatch LDR with r0=1 v0=16'h0010 and r1=0 tag 6'd3, then CDB tag 3 data 16'h0005 three cycles later -> issue one cycle after the broadcast with `val1`=16'h0005.
- CDB tag 3 in the same cycle as a dispatch waiting on tag 3 -> entry captured as ready; issue on the next edge.
- Four dispatches with `ld_busy`=1 -> `full`=1 and a fifth dispatch is ignored. Release `ld_busy` -> four pulses, each at least two cycles apart, in index order (or age order with the macro defined).
- Ready entry, `ld_busy` held high for 10 cycles -> no issue. `ld_busy` low -> `valid` on the next edge.
- Assert `rst` while two entries are pending and `valid`=1 -> `valid`=0 immediately; `full`=0 and `free_id`=16 after release.

Source files
------------

// File: rtl/ld_pkg.sv
// ld_pkg: shared opcode constants, tag width and the load reservation station entry record
package ld_pkg;
    localparam int TAG_W = 6;
    localparam logic [3:0] OP_LD = 4'd4;
    localparam logic [3:0] OP_LDR = 4'd5;
    typedef struct packed {
        logic valid;
        logic [3:0] op;
        logic [15:0] pc;
        logic r0;
        logic [15:0] v0;
        logic r1;
        logic [15:0] v1;
    } entry_t;
endpackage

// File: rtl/ld_rs_pick.sv
// ld_rs_pick: N-way selector returning the highest-age ready entry, lowest index on ties
module ld_rs_pick #(
    parameter int N = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]       ready_i,
    input  logic [N-1:0][1:0]  age_i,
    output logic [IW-1:0]      idx_o,
    output logic               hit_o
);
    logic [1:0] best;
    // Only a strictly older entry displaces an earlier pick, so equal ages favour the lower index
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        best = '0;
        for (int i = 0; i < N; i++) begin
            if (ready_i[i] && (!hit_o || age_i[i] > best)) begin
                idx_o = IW'(i);
                hit_o = 1'b1;
                best = age_i[i];
            end
        end
    end
endmodule

// File: rtl/ld_rs.sv
// ld_rs: four-entry load reservation station with CDB snooping and single-cycle issue pulses; LD_RS_OLDEST_FIRST_EN selects oldest-first issue
module ld_rs
    import ld_pkg::*;
#(
    parameter logic [TAG_W-1:0] BASE_ID = 6'd16,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [3:0]       d_op,
    input  logic [15:0]      d_pc,
    input  logic             d_r0,
    input  logic             d_r1,
    input  logic [15:0]      d_v0,
    input  logic [15:0]      d_v1,
    output logic [TAG_W-1:0] free_id,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_rs_num,
    input  logic [15:0]      cdb_data,
    input  logic             ld_busy,
    output logic             valid,
    output logic [TAG_W-1:0] rs_num,
    output logic [3:0]       op,
    output logic [15:0]      pc,
    output logic [15:0]      val0,
    output logic [15:0]      val1
);
    localparam int IW = 2;

    entry_t e_q [N];
    entry_t e_d [N];
    logic [N-1:0] rdy;
    logic [N-1:0][1:0] age_w;
    logic [IW-1:0] fidx, pidx;
    logic hit, issue, take, byp0, byp1;
    logic valid_q;
    logic [TAG_W-1:0] rs_num_q;
    logic [3:0] op_q;
    logic [15:0] pc_q, val0_q, val1_q;

    // Lowest free slot and fullness come from pre-edge state only
    always_comb begin
        full = 1'b1;
        fidx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!e_q[i].valid) begin
                full = 1'b0;
                fidx = IW'(i);
            end
        end
    end

    // An entry may issue once both operands are present
    always_comb begin
        for (int i = 0; i < N; i++) rdy[i] = e_q[i].valid && e_q[i].r0 && e_q[i].r1;
    end

    assign free_id = BASE_ID + TAG_W'(fidx);
    assign take = d_valid && !full;
    assign issue = !ld_busy && !valid_q && hit;
    assign byp0 = cdb_valid && !d_r0 && d_v0[TAG_W-1:0] == cdb_rs_num;
    assign byp1 = cdb_valid && !d_r1 && d_op != OP_LD && d_v1[TAG_W-1:0] == cdb_rs_num;

`ifdef LD_RS_OLDEST_FIRST_EN
    logic [N-1:0][1:0] age_q, age_d;
    // New entries start at age 0; every other live entry ages by one per dispatch, saturating
    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (take && fidx == IW'(i)) age_d[i] = 2'd0;
            else if (take && e_q[i].valid && age_q[i] != 2'd3) age_d[i] = age_q[i] + 2'd1;
        end
    end

    // Age register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) age_q <= '0;
        else age_q <= age_d;
    end
    assign age_w = age_q;
`else
    assign age_w = '0;
`endif

    ld_rs_pick #(.N(N), .IW(IW)) u_pick (
        .ready_i (rdy),
        .age_i   (age_w),
        .idx_o   (pidx),
        .hit_o   (hit)
    );

    // Entry update: CDB capture, free on issue, then dispatch write with same-cycle CDB bypass
    always_comb begin
        for (int i = 0; i < N; i++) begin
            e_d[i] = e_q[i];
            if (cdb_valid && e_q[i].valid && !e_q[i].r0 && e_q[i].v0[TAG_W-1:0] == cdb_rs_num) begin
                e_d[i].r0 = 1'b1;
                e_d[i].v0 = cdb_data;
            end
            if (cdb_valid && e_q[i].valid && !e_q[i].r1 && e_q[i].v1[TAG_W-1:0] == cdb_rs_num) begin
                e_d[i].r1 = 1'b1;
                e_d[i].v1 = cdb_data;
            end
            if (issue && pidx == IW'(i)) e_d[i].valid = 1'b0;
            if (take && fidx == IW'(i)) begin
                e_d[i].valid = 1'b1;
                e_d[i].op = d_op;
                e_d[i].pc = d_pc;
                e_d[i].r0 = d_r0 || byp0;
                e_d[i].v0 = byp0 ? cdb_data : d_v0;
                e_d[i].r1 = d_op == OP_LD || d_r1 || byp1;
                e_d[i].v1 = byp1 ? cdb_data : d_v1;
            end
        end
    end

    // Entry storage and issue bus; valid is a one-cycle pulse since issue requires valid_q low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) e_q[i] <= '0;
            valid_q <= 1'b0;
            rs_num_q <= '0;
            op_q <= '0;
            pc_q <= '0;
            val0_q <= '0;
            val1_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) e_q[i] <= e_d[i];
            valid_q <= issue;
            if (issue) begin
                rs_num_q <= BASE_ID + TAG_W'(pidx);
                op_q <= e_q[pidx].op;
                pc_q <= e_q[pidx].pc;
                val0_q <= e_q[pidx].v0;
                val1_q <= e_q[pidx].v1;
            end
        end
    end

    assign valid = valid_q;
    assign rs_num = rs_num_q;
    assign op = op_q;
    assign pc = pc_q;
    assign val0 = val0_q;
    assign val1 = val1_q;
endmodule
